mux4_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one 4:1 data multiplexer between four requesters.
//  It arbitrates req[3:0], registers a one-hot grant and drives the mux select.
//  sel=2'b00 selects i0, 01 selects i1, 10 selects i2 and 11 selects i3.
//  A hold limit stops any one requester from monopolising the shared path.

---
 rtl/mux4_rr_sched.sv | 133 +++++++++++++
 tb/tb_mux4_rr_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing one 4:1 data mux between four requesters.
// The grant is registered and one-hot, and a hold limit forces rotation while others wait.
module mux4_rr_sched #(
  parameter int DATA_W   = 1,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              busy,
  output logic [DATA_W-1:0] y
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] HOLD_ONE = CNT_W'(1);

  if (HOLD_MAX < 1 || HOLD_MAX >= (1 << CNT_W)) begin : g_bad_params
    $error("mux4_rr_sched: HOLD_MAX must be >= 1 and below 2**CNT_W");
  end

  logic [0:0]       r_state,    w_state_nxt;
  logic [3:0]       r_gnt,      w_gnt_nxt;
  logic [1:0]       r_sel,      w_sel_nxt;
  logic [1:0]       r_last,     w_last_nxt;
  logic [CNT_W-1:0] r_hold_cnt, w_hold_nxt;

  logic [3:0] w_cand;
  logic       w_own_req;
  logic       w_found;
  logic [1:0] w_win;
  logic       w_take;

  // While granted the owner is masked out, so it can only win again by default (lowest priority).
  assign w_own_req = |(req & r_gnt);
  assign w_cand    = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_found = 1'b0;
    w_win   = r_last;
    for (int k = 1; k <= 4; k++) begin
      if (!w_found && w_cand[r_last + 2'(k)]) begin
        w_found = 1'b1;
        w_win   = r_last + 2'(k);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_take      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_take = w_found;
      end
      ST_GRANT: begin
        if (!w_own_req) begin
          if (w_found) begin
            w_take = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
            w_gnt_nxt   = 4'b0000;
          end
        end else if (r_hold_cnt < HOLD_LIM) begin
          w_hold_nxt = r_hold_cnt + HOLD_ONE;
        end else begin
          // Limit reached: rotate only if someone else waits, else keep with a saturated count.
          w_take = w_found;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = 4'b0000;
      end
    endcase

    if (w_take) begin
      w_state_nxt = ST_GRANT;
      w_gnt_nxt   = 4'b0001 << w_win;
      w_sel_nxt   = w_win;
      w_last_nxt  = w_win;
      w_hold_nxt  = HOLD_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= 4'b0000;
      r_sel      <= 2'b00;
      r_last     <= 2'd3;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_sel      <= w_sel_nxt;
      r_last     <= w_last_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  assign gnt  = r_gnt;
  assign sel  = r_sel;
  assign busy = |r_gnt;

  always_comb begin
    y = '0;
    if (busy) begin
      case (r_sel)
        2'd0:    y = i0;
        2'd1:    y = i1;
        2'd2:    y = i2;
        default: y = i3;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: directed vectors push expected grants, a monitor checks them,
// then a random phase checks one-hot grant, select consistency and waiting-time bound.
module tb_mux4_rr_sched;

  localparam int DATA_W   = 4;
  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;
  localparam int WAIT_BOUND = 3 * HOLD_MAX + 3;

  localparam logic [3:0] D0 = 4'h3;
  localparam logic [3:0] D1 = 4'h5;
  localparam logic [3:0] D2 = 4'h9;
  localparam logic [3:0] D3 = 4'hE;

  logic              clk;
  logic              rst_n;
  logic [3:0]        req;
  logic [DATA_W-1:0] i0, i1, i2, i3;
  logic [3:0]        gnt;
  logic [1:0]        sel;
  logic              busy;
  logic [DATA_W-1:0] y;

  mux4_rr_sched #(
    .DATA_W  (DATA_W),
    .HOLD_MAX(HOLD_MAX),
    .CNT_W   (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .i0   (i0),
    .i1   (i1),
    .i2   (i2),
    .i3   (i3),
    .gnt  (gnt),
    .sel  (sel),
    .busy (busy),
    .y    (y)
  );

  typedef struct {
    int         cyc;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] y;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   cycle    = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  function automatic logic [3:0] exp_y(input logic [3:0] g);
    case (g)
      4'b0001: return D0;
      4'b0010: return D1;
      4'b0100: return D2;
      4'b1000: return D3;
      default: return 4'h0;
    endcase
  endfunction

  // Drive one request vector and queue the grant expected after the next edge.
  task automatic step(input logic [3:0] r, input logic [3:0] eg, input logic [1:0] es,
                      input string nm);
    exp_t e;
    req    = r;
    e.cyc  = cycle + 1;
    e.gnt  = eg;
    e.sel  = es;
    e.busy = |eg;
    e.y    = exp_y(eg);
    e.name = nm;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    #2;
    check("rst_gnt",  32'(gnt),  32'h0);
    check("rst_sel",  32'(sel),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_y",    32'(y),    32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every queued expectation on the falling edge of its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cycle) begin
        e = sb_q.pop_front();
        if (e.cyc < cycle) begin
          check({e.name, ".missed"}, 32'(cycle), 32'(e.cyc));
        end else begin
          check({e.name, ".gnt"},  32'(gnt),  32'(e.gnt));
          check({e.name, ".sel"},  32'(sel),  32'(e.sel));
          check({e.name, ".busy"}, 32'(busy), 32'(e.busy));
          check({e.name, ".y"},    32'(y),    32'(e.y));
        end
      end
    end
  end

  initial begin
    int         wait_cnt [4];
    int         worst;
    logic [3:0] r;

    rst_n = 1'b0;
    req   = 4'b0000;
    i0 = D0; i1 = D1; i2 = D2; i3 = D3;
    #1;
    apply_reset();

    // Single request gets the path one cycle later.
    step(4'b0001, 4'b0001, 2'd0, "t1_grant0");
    step(4'b0000, 4'b0000, 2'd0, "t1_release");

    // Full load after reset: 0,1,2,3,0 each held exactly HOLD_MAX cycles, no bubbles.
    apply_reset();
    for (int t = 0; t < 40; t++) begin
      step(4'b1111, 4'b0001 << ((t / HOLD_MAX) % 4), 2'((t / HOLD_MAX) % 4), "t2_rotate");
    end
    step(4'b0000, 4'b0000, 2'd0, "t2_idle");

    // Owner 2 releases while 0,1,3 wait: 3 is next after 2, then 0, then 1.
    for (int t = 0; t < 3; t++) step(4'b0100, 4'b0100, 2'd2, "t3_own2");
    step(4'b1011, 4'b1000, 2'd3, "t3_hand3");
    step(4'b0011, 4'b0001, 2'd0, "t3_hand0");
    step(4'b0010, 4'b0010, 2'd1, "t3_hand1");
    step(4'b0000, 4'b0000, 2'd1, "t3_idle_keep_sel");

    // Lone requester keeps the grant past the limit, then yields at once to a newcomer.
    for (int t = 0; t < 20; t++) step(4'b0100, 4'b0100, 2'd2, "t4_alone");
    step(4'b0101, 4'b0001, 2'd0, "t4_forced");
    for (int t = 0; t < HOLD_MAX - 1; t++) step(4'b0101, 4'b0001, 2'd0, "t4_hold0");
    step(4'b0101, 4'b0100, 2'd2, "t4_back2");
    step(4'b0000, 4'b0000, 2'd2, "t4_idle");

    // Asynchronous reset mid-grant.
    step(4'b0010, 4'b0010, 2'd1, "t5_grant1");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    req   = 4'b1111;
    #1;
    check("t5_async_gnt",  32'(gnt),  32'h0);
    check("t5_async_busy", 32'(busy), 32'h0);
    check("t5_async_y",    32'(y),    32'h0);
    check("t5_async_sel",  32'(sel),  32'h0);
    @(posedge clk);
    #1;
    check("t5_held_gnt", 32'(gnt), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(4'b1111, 4'b0001, 2'd0, "t5_first0");
    step(4'b1111, 4'b0001, 2'd0, "t5_keep0");
    step(4'b0000, 4'b0000, 2'd0, "t5_idle");

    // Random load: invariants and bounded waiting.
    for (int k = 0; k < 4; k++) wait_cnt[k] = 0;
    for (int n = 0; n < 10000; n++) begin
      r   = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      req = r;
      @(negedge clk);
      worst = 0;
      for (int k = 0; k < 4; k++) begin
        if (req[k] && !gnt[k]) wait_cnt[k]++;
        else                   wait_cnt[k] = 0;
        if (wait_cnt[k] > worst) worst = wait_cnt[k];
      end
      check("r_onehot", 32'($onehot0(gnt)), 32'h1);
      check("r_busy",   32'(busy),          32'(|gnt));
      check("r_y",      32'(y),             32'(exp_y(gnt)));
      if (busy) check("r_sel_gnt", 32'(gnt), 32'(4'b0001 << sel));
      check("r_wait_bound", 32'(worst <= WAIT_BOUND), 32'h1);
      @(posedge clk);
      #1;
    end

    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
